axi64_slave_mem: RTL and testbench

// Synthesizable AXI3-style 64-bit slave memory: the responder end of the DMA engine's AXI master port.

---
 rtl/axi64_slave_mem.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi64_slave_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi64_slave_mem.sv
// axi64_slave_mem: AXI3-style 64-bit slave memory.
// Independent write (AW/W/B) and read (AR/R) FSMs share one word-addressed array.
// Both paths accept INCR bursts only, with one burst outstanding per path.
module axi64_slave_mem #(
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 1,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [1:0]        AWSIZE,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ID_W-1:0]   WID,
    input  logic [63:0]       WDATA,
    input  logic [7:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [1:0]        ARSIZE,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int WORD_W = ADDR_W - 3;
    // One extra bit so base + beat cannot wrap back into the array.
    localparam int EXT_W  = ADDR_W - 2;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [63:0] mem [DEPTH];

    // Byte offsets within a word are ignored; only the word address is used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[2:0], ARADDR[2:0]};

    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [WORD_W-1:0] w_base_q, w_base_d;
    logic [3:0]        w_len_q, w_len_d;
    logic [3:0]        w_beat_q, w_beat_d;
    logic              w_size_bad_q, w_size_bad_d;
    logic              w_err_q, w_err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [EXT_W-1:0]  w_word;
    logic              w_last_beat;
    logic              w_beat_err;
    logic              mem_we;

    assign w_word      = {1'b0, w_base_q} + {{(EXT_W-4){1'b0}}, w_beat_q};
    assign w_last_beat = (w_beat_q == w_len_q);
    assign w_beat_err  = w_size_bad_q | (|w_word[EXT_W-1:DEPTH_LOG2]) |
                         (WID != w_id_q) | (WLAST != w_last_beat);

    // Write FSM next state: latch AW, count beats to LEN, then hold B until BREADY.
    always_comb begin
        w_state_d    = w_state_q;
        w_id_d       = w_id_q;
        w_base_d     = w_base_q;
        w_len_d      = w_len_q;
        w_beat_d     = w_beat_q;
        w_size_bad_d = w_size_bad_q;
        w_err_d      = w_err_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        mem_we       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && awready_q) begin
                    w_id_d       = AWID;
                    w_base_d     = AWADDR[ADDR_W-1:3];
                    w_len_d      = AWLEN;
                    w_size_bad_d = (AWSIZE != 2'd3);
                    w_beat_d     = 4'd0;
                    w_err_d      = 1'b0;
                    w_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    mem_we  = ~w_beat_err;
                    w_err_d = w_err_q | w_beat_err;
                    if (w_last_beat) begin
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_q | w_beat_err) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM state and registered write-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q    <= W_IDLE;
            w_id_q       <= '0;
            w_base_q     <= '0;
            w_len_q      <= '0;
            w_beat_q     <= '0;
            w_size_bad_q <= 1'b0;
            w_err_q      <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= '0;
        end else begin
            w_state_q    <= w_state_d;
            w_id_q       <= w_id_d;
            w_base_q     <= w_base_d;
            w_len_q      <= w_len_d;
            w_beat_q     <= w_beat_d;
            w_size_bad_q <= w_size_bad_d;
            w_err_q      <= w_err_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bid_q        <= bid_d;
            bresp_q      <= bresp_d;
        end
    end

    // Byte-strobed memory write on each good W beat; the array keeps its contents over reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (WSTRB[i]) begin
                    mem[w_word[DEPTH_LOG2-1:0]][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    r_state_t          r_state_q, r_state_d;
    logic [WORD_W-1:0] r_base_q, r_base_d;
    logic [3:0]        r_len_q, r_len_d;
    logic [3:0]        r_beat_q, r_beat_d;
    logic              r_size_bad_q, r_size_bad_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              r_load;
    logic [EXT_W-1:0]  r_word;
    logic              r_beat_err;

    // Read FSM next state: load the next beat into the R registers on AR accept or R handshake.
    always_comb begin
        r_state_d    = r_state_q;
        r_base_d     = r_base_q;
        r_len_d      = r_len_q;
        r_beat_d     = r_beat_q;
        r_size_bad_d = r_size_bad_q;
        rvalid_d     = rvalid_q;
        rid_d        = rid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        rlast_d      = rlast_q;
        r_load       = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    rid_d        = ARID;
                    r_base_d     = ARADDR[ADDR_W-1:3];
                    r_len_d      = ARLEN;
                    r_size_bad_d = (ARSIZE != 2'd3);
                    r_beat_d     = 4'd0;
                    r_load       = 1'b1;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 4'd1;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        r_word     = {1'b0, r_base_d} + {{(EXT_W-4){1'b0}}, r_beat_d};
        r_beat_err = r_size_bad_d | (|r_word[EXT_W-1:DEPTH_LOG2]);
        if (r_load) begin
            rvalid_d = 1'b1;
            rlast_d  = (r_beat_d == r_len_d);
            rresp_d  = r_beat_err ? 2'b10 : 2'b00;
            rdata_d  = r_beat_err ? 64'd0 : mem[r_word[DEPTH_LOG2-1:0]];
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // Read FSM state and registered read-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= R_IDLE;
            r_base_q     <= '0;
            r_len_q      <= '0;
            r_beat_q     <= '0;
            r_size_bad_q <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rlast_q      <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            r_base_q     <= r_base_d;
            r_len_q      <= r_len_d;
            r_beat_q     <= r_beat_d;
            r_size_bad_q <= r_size_bad_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rid_q        <= rid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rlast_q      <= rlast_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi64_slave_mem.sv
// tb_axi64_slave_mem: directed write/read bursts against a reference word model.
// Expected B and R results are queued when a burst is issued and compared as the DUT responds.
module tb_axi64_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [3:0]  AWLEN, ARLEN;
    logic [1:0]  AWSIZE, ARSIZE, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;

    axi64_slave_mem dut (
        .clk(clk), .reset(reset),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  id;
    } rbeat_t;

    typedef struct {
        logic [1:0] resp;
        logic [0:0] id;
    } bexp_t;

    rbeat_t      r_exp_q[$];
    bexp_t       b_exp_q[$];
    logic [63:0] ref_mem [int];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expected R beats of a burst from the reference model.
    task automatic push_read(input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] size, input logic [0:0] id);
        rbeat_t e;
        for (int n = 0; n <= int'(len); n++) begin
            int  word;
            bit  err;
            word   = int'(addr >> 3) + n;
            err    = (size != 2'd3) || (word >= 1024);
            e.data = err ? 64'd0 : (ref_mem.exists(word) ? ref_mem[word] : 64'hx);
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (n == int'(len));
            e.id   = id;
            r_exp_q.push_back(e);
        end
    endtask

    // Update the model, queue the B response, then drive AW, all W beats and accept B.
    task automatic applyWrite(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] size,
                              input logic [0:0] id, input logic [63:0] d0, input bit incr,
                              input logic [7:0] strb, input int early);
        bit    err;
        int    n;
        bexp_t be;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            int          word;
            bit          last;
            logic [63:0] d, old;
            word = int'(addr >> 3) + i;
            last = (i == int'(len)) || (i == early);
            d    = incr ? d0 + 64'(i) : d0;
            if ((size != 2'd3) || (word >= 1024) || (last != (i == int'(len)))) begin
                err = 1'b1;
            end else begin
                old = ref_mem.exists(word) ? ref_mem[word] : 64'd0;
                for (int b = 0; b < 8; b++) if (strb[b]) old[8*b +: 8] = d[8*b +: 8];
                ref_mem[word] = old;
            end
        end
        be.resp = err ? 2'b10 : 2'b00;
        be.id   = id;
        b_exp_q.push_back(be);

        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        check("aw_ready", 64'(AWREADY), 64'd1);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WID = id; WSTRB = strb;
            WDATA = incr ? d0 + 64'(i) : d0;
            WLAST = (i == int'(len)) || (i == early);
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            check("w_ready", 64'(WREADY), 64'd1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        check("b_valid", 64'(BVALID), 64'd1);
        be = b_exp_q.pop_front();
        check("b_resp", 64'(BRESP), 64'(be.resp));
        check("b_id", 64'(BID), 64'(be.id));
        @(negedge clk);
        BREADY = 1'b0;
        check("b_drop", 64'(BVALID), 64'd0);
    endtask

    // Drive AR, then collect beats against the queue; toggle=1 alternates RREADY to test stalls.
    task automatic applyRead(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] size,
                             input logic [0:0] id, input bit toggle, input bit pre);
        int          n, cyc, first_cyc, last_cyc;
        bit          done, held;
        logic [63:0] held_data;
        rbeat_t      e;
        if (!pre) push_read(addr, len, size, id);
        first_cyc = -1; last_cyc = -1; done = 1'b0; held = 1'b0; held_data = '0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        check("ar_ready", 64'(ARREADY), 64'd1);
        @(negedge clk);
        ARVALID = 1'b0;
        check("r_latency", 64'(RVALID), 64'd1);
        cyc = 0;
        while (!done && cyc < 200) begin
            RREADY = toggle ? cyc[0] : 1'b1;
            if (RVALID) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held) check("r_stall_stable", RDATA, held_data);
                if (RREADY) begin
                    held = 1'b0;
                    if (r_exp_q.size() == 0) begin
                        check("r_unexpected", 64'(RVALID), 64'd0);
                        done = 1'b1;
                    end else begin
                        e = r_exp_q.pop_front();
                        check("r_data", RDATA, e.data);
                        check("r_resp", 64'(RRESP), 64'(e.resp));
                        check("r_last", 64'(RLAST), 64'(e.last));
                        check("r_id", 64'(RID), 64'(e.id));
                        if (e.last) begin done = 1'b1; last_cyc = cyc; end
                    end
                end else begin
                    held = 1'b1;
                    held_data = RDATA;
                end
            end
            @(negedge clk);
            cyc++;
        end
        RREADY = 1'b0;
        check("r_complete", 64'(done), 64'd1);
        check("r_idle_after", 64'(RVALID), 64'd0);
        if (!toggle) check("r_zero_bubble", 64'(last_cyc - first_cyc), 64'(len));
    endtask

    // Watchdog so a stuck handshake still terminates the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, basic/burst/strobe/error/concurrency/reset-mid-burst cases.
    initial begin
        reset = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RRESP, RLAST}), 64'd0);
        check("rst_rdata", RDATA, 64'd0);
        reset = 1'b0;
        #1;
        check("awready_before_edge", 64'(AWREADY), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'({AWREADY, ARREADY}), 64'd3);

        $display("[TB] single write/read");
        applyWrite(32'h40, 4'd0, 2'd3, 1'b1, 64'h1122334455667788, 1'b0, 8'hFF, -1);
        applyRead(32'h40, 4'd0, 2'd3, 1'b1, 1'b0, 1'b0);

        $display("[TB] 8-beat burst, no backpressure");
        applyWrite(32'h100, 4'd7, 2'd3, 1'b0, 64'd1, 1'b1, 8'hFF, -1);
        applyRead(32'h100, 4'd7, 2'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] strobes and RREADY backpressure");
        applyWrite(32'h80, 4'd0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8'hFF, -1);
        applyWrite(32'h80, 4'd0, 2'd3, 1'b0, 64'h0, 1'b0, 8'h0F, -1);
        applyWrite(32'h88, 4'd0, 2'd3, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 8'hFF, -1);
        applyRead(32'h80, 4'd1, 2'd3, 1'b1, 1'b1, 1'b0);
        applyRead(32'h100, 4'd7, 2'd3, 1'b1, 1'b1, 1'b0);

        $display("[TB] error cases");
        applyWrite(32'h40, 4'd0, 2'd2, 1'b0, 64'h0, 1'b0, 8'hFF, -1);
        applyRead(32'h40, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        applyWrite(32'h1FF8, 4'd0, 2'd3, 1'b0, 64'h0123456789ABCDEF, 1'b0, 8'hFF, -1);
        applyRead(32'h1FF8, 4'd1, 2'd3, 1'b1, 1'b0, 1'b0);
        applyWrite(32'h500, 4'd1, 2'd3, 1'b0, 64'h5555AAAA00000010, 1'b1, 8'hFF, 0);
        applyRead(32'h508, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] concurrent read and write of 0x200");
        applyWrite(32'h200, 4'd3, 2'd3, 1'b0, 64'hA0, 1'b1, 8'hFF, -1);
        push_read(32'h200, 4'd3, 2'd3, 1'b1);
        fork
            applyWrite(32'h200, 4'd3, 2'd3, 1'b1, 64'hB0, 1'b1, 8'hFF, -1);
            applyRead(32'h200, 4'd3, 2'd3, 1'b1, 1'b0, 1'b1);
        join
        applyRead(32'h200, 4'd3, 2'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during beat 3 of an 8-beat write");
        AWID = 1'b0; AWADDR = 32'h300; AWLEN = 4'd7; AWSIZE = 2'd3; AWVALID = 1'b1;
        for (int n = 0; n < 50 && !AWREADY; n++) @(negedge clk);
        check("mid_aw_ready", 64'(AWREADY), 64'd1);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            WID = 1'b0; WSTRB = 8'hFF; WDATA = 64'hC0 + 64'(i); WLAST = 1'b0; WVALID = 1'b1;
            for (int n = 0; n < 50 && !WREADY; n++) @(negedge clk);
            check("mid_w_ready", 64'(WREADY), 64'd1);
            ref_mem[(32'h300 >> 3) + i] = 64'hC0 + 64'(i);
            @(negedge clk);
        end
        WDATA = 64'hC3; WVALID = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 64'd0);
        check("mid_rst_rdata", RDATA, 64'd0);
        @(negedge clk);
        WVALID = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("mid_ready_back", 64'({AWREADY, ARREADY, BVALID}), 64'd6);
        applyRead(32'h300, 4'd2, 2'd3, 1'b0, 1'b0, 1'b0);
        applyWrite(32'h300, 4'd7, 2'd3, 1'b1, 64'hD0, 1'b1, 8'hFF, -1);
        applyRead(32'h318, 4'd0, 2'd3, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
